// File: rtl/onchip_mem_stream_writer_pkg.sv
// Shared definitions for the on-chip memory stream writer.
//   - FSM state encoding
//   - CSR word offsets and CTRL / STATUS bit positions
//   - default RAM depth
package onchip_mem_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // CSR word offsets (CTRL on write, STATUS on read share offset 0)
  localparam logic [1:0] CSR_CTRL       = 2'd0;
  localparam logic [1:0] CSR_STATUS     = 2'd0;
  localparam logic [1:0] CSR_START_ADDR = 2'd1;
  localparam logic [1:0] CSR_LENGTH     = 2'd2;
  localparam logic [1:0] CSR_CHECKSUM   = 2'd3;

  // CTRL bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;

  // STATUS bits
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_EOP_TERM = 2;
  localparam int ST_ERR      = 3;
  localparam int ST_WW_LSB   = 16;
  localparam int ST_WW_MSB   = 30;

  localparam int MEM_WORDS_DEFAULT = 30000;

endpackage

// File: rtl/onchip_mem_stream_writer_if.sv
// Bus bundle for the on-chip memory stream writer: CSR slave, Avalon-ST
// sink and the Avalon-MM master towards the RAM s1 port.
//   slave  : the writer block's view (receives CSR/stream, drives RAM pins)
//   master : the environment's view (CPU, stream source and RAM)
interface onchip_mem_stream_writer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [1:0]        csr_address;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic              csr_read;
  logic [31:0]       csr_readdata;

  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic              snk_endofpacket;

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;

  modport slave (
    input  csr_address, csr_write, csr_writedata, csr_read,
    output csr_readdata,
    input  snk_data, snk_valid, snk_endofpacket,
    output snk_ready,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken
  );

  modport master (
    output csr_address, csr_write, csr_writedata, csr_read,
    input  csr_readdata,
    output snk_data, snk_valid, snk_endofpacket,
    input  snk_ready,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_mem_stream_writer_csr.sv
// CSR register file for the stream writer.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   csr_*                   CSR slave (read latency 1)
//   status_word, checksum   live values returned on reads of offsets 0 / 3
//   start_addr, length      programmed transfer parameters
//   ctrl_start/abort/clr_done  single-cycle CTRL strobes (self-clearing)
module onchip_mem_writer_csr
  import onchip_mem_writer_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  input  logic [31:0]       status_word,
  input  logic [31:0]       checksum,
  output logic [ADDR_W-1:0] start_addr,
  output logic [15:0]       length,
  output logic              ctrl_start,
  output logic              ctrl_abort,
  output logic              ctrl_clr_done
);

  logic ctrl_wr;
  logic unused_wdata;

  assign ctrl_wr       = csr_write && (csr_address == CSR_CTRL);
  assign ctrl_start    = ctrl_wr && csr_writedata[CTRL_START];
  assign ctrl_abort    = ctrl_wr && csr_writedata[CTRL_ABORT];
  assign ctrl_clr_done = ctrl_wr && csr_writedata[CTRL_CLR_DONE];
  assign unused_wdata  = ^csr_writedata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_addr   <= '0;
      length       <= '0;
      csr_readdata <= '0;
    end else begin
      if (csr_write && (csr_address == CSR_START_ADDR))
        start_addr <= csr_writedata[ADDR_W-1:0];
      if (csr_write && (csr_address == CSR_LENGTH))
        length <= csr_writedata[15:0];
      if (csr_read) begin
        case (csr_address)
          CSR_STATUS:     csr_readdata <= status_word;
          CSR_START_ADDR: csr_readdata <= 32'(start_addr);
          CSR_LENGTH:     csr_readdata <= 32'(length);
          default:        csr_readdata <= checksum;
        endcase
      end
    end
  end

endmodule

// File: rtl/onchip_mem_stream_writer.sv
// Avalon-ST to on-chip RAM writer. Accepts one stream word per clock and
// writes it to consecutive RAM word addresses (wrapping at MEM_WORDS) one
// cycle after acceptance.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   bus (slave)   CSR slave, stream sink, RAM s1 master pins
// Optional: define ONCHIP_MEM_WRITER_CHECKSUM_EN for a running 32-bit sum
// of written words at CSR 3 (reads 0 otherwise).
module onchip_mem_stream_writer
  import onchip_mem_writer_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  onchip_mem_stream_writer_if.slave   bus
);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_next;
  logic [15:0]       remaining;
  logic [14:0]       words_written;
  logic              done_r;
  logic              eop_term;
  logic              err;
  logic              wr_pending;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [31:0]       status_word;
  logic [31:0]       checksum;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0]       length;
  logic              ctrl_start;
  logic              ctrl_abort;
  logic              ctrl_clr_done;
  logic              start_ok;
  logic              beat;

  onchip_mem_writer_csr #(.ADDR_W(ADDR_W)) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (bus.csr_address),
    .csr_write     (bus.csr_write),
    .csr_writedata (bus.csr_writedata),
    .csr_read      (bus.csr_read),
    .csr_readdata  (bus.csr_readdata),
    .status_word   (status_word),
    .checksum      (checksum),
    .start_addr    (start_addr),
    .length        (length),
    .ctrl_start    (ctrl_start),
    .ctrl_abort    (ctrl_abort),
    .ctrl_clr_done (ctrl_clr_done)
  );

  // ABORT drops ready in the same cycle so no further beat is taken.
  assign bus.snk_ready      = (state == RUN) && !ctrl_abort;
  assign beat               = bus.snk_ready && bus.snk_valid;
  assign start_ok           = (state == IDLE) && ctrl_start &&
                              (32'(start_addr) < 32'(MEM_WORDS));
  assign addr_next          = (32'(addr_cnt) == 32'(MEM_WORDS - 1)) ? '0
                                                                   : addr_cnt + ADDR_W'(1);

  assign bus.mem_address    = mem_address_r;
  assign bus.mem_writedata  = mem_wdata_r;
  assign bus.mem_write      = wr_pending;
  assign bus.mem_chipselect = wr_pending;
  assign bus.mem_byteenable = {4{wr_pending}};
  assign bus.mem_clken      = 1'b1;

  always_comb begin
    status_word                        = '0;
    status_word[ST_BUSY]               = (state != IDLE);
    status_word[ST_DONE]               = done_r;
    status_word[ST_EOP_TERM]           = eop_term;
    status_word[ST_ERR]                = err;
    status_word[ST_WW_MSB:ST_WW_LSB]   = words_written;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr_cnt      <= '0;
      remaining     <= '0;
      words_written <= '0;
      done_r        <= 1'b0;
      eop_term      <= 1'b0;
      err           <= 1'b0;
      wr_pending    <= 1'b0;
      mem_address_r <= '0;
      mem_wdata_r   <= '0;
    end else begin
      // Accepted beat is written on the following cycle regardless of the
      // state change it causes (DONE or an ABORT arriving next cycle).
      wr_pending <= beat;
      if (beat) begin
        mem_address_r <= addr_cnt;
        mem_wdata_r   <= bus.snk_data;
      end

      if (ctrl_clr_done) begin
        done_r   <= 1'b0;
        eop_term <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ctrl_start) begin
            if (!start_ok) begin
              err <= 1'b1;
            end else begin
              err           <= 1'b0;
              done_r        <= 1'b0;
              eop_term      <= 1'b0;
              words_written <= '0;
              addr_cnt      <= start_addr;
              remaining     <= length;
              state         <= (length == 16'd0) ? DONE : RUN;
            end
          end
        end
        RUN: begin
          if (ctrl_abort) begin
            state <= IDLE;
          end else if (beat) begin
            addr_cnt      <= addr_next;
            remaining     <= remaining - 16'd1;
            words_written <= words_written + 15'd1;
            if (bus.snk_endofpacket)
              eop_term <= 1'b1;
            if ((remaining == 16'd1) || bus.snk_endofpacket)
              state <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ONCHIP_MEM_WRITER_CHECKSUM_EN
  logic [31:0] checksum_r;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      checksum_r <= '0;
    else if (start_ok)
      checksum_r <= '0;
    else if (wr_pending)
      checksum_r <= checksum_r + 32'(mem_wdata_r);
  end
  assign checksum = checksum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/onchip_mem_stream_writer.md
Name: onchip_mem_stream_writer

Overview:
- Avalon-MM master that fills the 32-bit single-port on-chip RAM from an Avalon-ST sink stream.
- Sits directly upstream of the RAM's s1 slave and drives its address, byteenable, chipselect, write, writedata and clken pins.
- The NIOS CPU programs a start word address and a length through a small CSR slave, then polls status.
- Throughput: one word per clock.

Parameters:
- MEM_WORDS, 30000, RAM depth in 32-bit words; the write address wraps at this value.
- ADDR_W, 15, RAM word-address width.
- DATA_W, 32, stream and RAM data width; fixed at 32.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- csr_address  in  2  CSR word select
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  CSR read data, read latency 1
- snk_data  in  32  stream word
- snk_valid  in  1  stream word valid
- snk_ready  out  1  block accepts the word this cycle
- snk_endofpacket  in  1  last word of packet
- mem_address  out  15  RAM word address
- mem_byteenable  out  4  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable; constant 1

Behaviour:
- Reset: all outputs 0 except mem_clken=1; state=IDLE; all CSRs 0.
- CSR map:
  - 0 CTRL, write-only. bit0 START, bit1 ABORT, bit2 CLR_DONE; self-clearing.
  - 0 read returns STATUS: bit0 busy, bit1 done (sticky), bit2 eop_term, bit3 err, bits[30:16] words_written.
  - 1 START_ADDR, bits[14:0], R/W.
  - 2 LENGTH in words, bits[15:0], R/W.
  - 3 CHECKSUM (see Optional Feature).
  - csr_readdata is registered and valid the cycle after csr_read.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE, START with START_ADDR>=MEM_WORDS: set err, stay in IDLE.
  - IDLE, START with LENGTH==0: go to DONE with words_written=0.
  - IDLE, START otherwise: load addr_cnt=START_ADDR and remaining=LENGTH; clear words_written, eop_term, err and done; go to RUN.
  - RUN: snk_ready=1. On a snk_valid&snk_ready beat:
    - register data and address;
    - next cycle drive mem_write=mem_chipselect=1 and mem_byteenable=4'hF;
    - addr_cnt increments, wrapping MEM_WORDS-1 -> 0;
    - remaining decrements; words_written increments.
  - RUN -> DONE when the accepted beat has remaining==1, or has snk_endofpacket=1 (sets eop_term). If both happen on the same beat, the block goes to DONE with eop_term=1.
  - DONE: snk_ready=0; the pending registered write still issues this cycle; set done; go to IDLE next cycle.
  - ABORT in RUN: snk_ready drops the same cycle; an already-accepted word is still written; go to IDLE; done stays 0.
- START while busy is ignored.
- CLR_DONE clears done and eop_term.
- Register writes to START_ADDR and LENGTH while busy take effect on the next START only.
- RAM has no waitrequest, so writes complete in one cycle; mem_write is never asserted for two beats carrying the same data.
- Asynchronous reset mid-transfer aborts immediately. A write that is in flight may or may not land.

Optional Feature:
- Macro ONCHIP_MEM_WRITER_CHECKSUM_EN.
- Defined: a 32-bit modulo-2^32 running sum of every word written to RAM, cleared on START, readable at CSR 3.
- Undefined: no adder; CSR 3 reads 0.

Decomposition:
- Shared package onchip_mem_writer_pkg holds:
  - FSM state enum {IDLE, RUN, DONE};
  - CSR offset constants CTRL/STATUS=0, START_ADDR=1, LENGTH=2, CHECKSUM=3;
  - STATUS bit-index constants;
  - MEM_WORDS default.
- One natural sub-module, onchip_mem_writer_csr: register file, strobe decode and registered readback. The FSM and datapath stay in the top module.

Test Plan:
- START_ADDR=0x10, LENGTH=4, stream 0xA0..0xA3 with valid held -> mem writes at 0x10..0x13 on consecutive cycles, each one cycle after acceptance; then done=1, words_written=4, eop_term=0.
- START_ADDR=29998, LENGTH=4 -> write addresses 29998, 29999, 0, 1.
- LENGTH=8, snk_endofpacket on the 3rd word -> 3 writes, done=1, eop_term=1, snk_ready=0 after that beat.
- ABORT one cycle after the 2nd beat is accepted -> exactly 2 writes, state IDLE, done=0; a following START works normally.
- LENGTH=0 -> done=1 with zero writes. START_ADDR=30000 -> err=1, busy never set, no writes.
- CHECKSUM_EN defined, words 0xFFFFFFFF and 0x2 -> CSR 3 reads 0x00000001. Undefined -> CSR 3 reads 0.
